ntt_butterfly_exec: RTL and testbench

Execution end of the NTT address stream. Consumes the per-butterfly address triplets (u, v, twiddle) and `valid`/`done` from the NTT address controller. For each triplet it reads two coefficients and one twiddle from synchronous RAMs, computes a Cooley-Tukey modular butterfly in a fixed 4-cycle pipeline, and writes both results back. It reports completion, a butterfly count, and a sticky read-after-write hazard flag, because the controller cannot be stalled.

---
 rtl/ntt_butterfly_exec.sv | 143 ++++++++++++++
 tb/tb_ntt_butterfly_exec.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_butterfly_exec.sv
// Execution stage for the NTT address stream: reads u, v and twiddle, runs a 4-cycle
// Cooley-Tukey modular butterfly, writes u', v' back and flags read-after-write hazards.
module ntt_butterfly_exec #(
  parameter int N_LOG = 12,
  parameter int N = 4096,
  parameter int W = 32,
  parameter logic [W-1:0] Q = W'(998244353)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic [N_LOG-1:0]     in_addr_u,
  input  logic [N_LOG-1:0]     in_addr_v,
  input  logic [N_LOG-1:0]     in_addr_w,
  input  logic                 in_done,
  output logic                 rd_en,
  output logic [N_LOG-1:0]     rd_addr_a,
  output logic [N_LOG-1:0]     rd_addr_b,
  output logic [N_LOG-1:0]     tw_addr,
  input  logic [W-1:0]         rd_data_a,
  input  logic [W-1:0]         rd_data_b,
  input  logic [W-1:0]         tw_data,
  output logic                 wr_en,
  output logic [N_LOG-1:0]     wr_addr_a,
  output logic [N_LOG-1:0]     wr_addr_b,
  output logic [W-1:0]         wr_data_a,
  output logic [W-1:0]         wr_data_b,
  output logic                 busy,
  output logic                 done_out,
  output logic [2*N_LOG-1:0]   op_count,
  output logic                 hazard_err
);

  localparam logic [N_LOG-1:0] ADDR_MASK = N_LOG'(N - 1);
  localparam logic [2*W-1:0]   Q_WIDE    = {{W{1'b0}}, Q};
  localparam logic [W:0]       Q_EXT     = {1'b0, Q};

  logic             v1, v2, v3;
  logic [N_LOG-1:0] a1_u, a1_v, a2_u, a2_v, a3_u, a3_v;
  logic [W-1:0]     u2, u3, t3;
  logic [2*W-1:0]   prod2;

  logic [2*W-1:0]   prod_next;
  logic [W-1:0]     t_next;
  logic [W:0]       sum;
  logic [W:0]       sum_red;
  logic [W-1:0]     u_out_next;
  logic [W-1:0]     v_out_next;
  logic             hazard_hit;

  function automatic logic addr_hit(input logic [N_LOG-1:0] a, input logic valid,
                                    input logic [N_LOG-1:0] x, input logic [N_LOG-1:0] y);
    return valid && ((a == x) || (a == y));
  endfunction

  assign rd_en     = in_valid;
  assign rd_addr_a = in_addr_u;
  assign rd_addr_b = in_addr_v;
  assign tw_addr   = in_addr_w;
  assign busy      = in_valid | v1 | v2 | v3 | wr_en;

  // Butterfly arithmetic; operands below Q keep both results below Q without a second correction
  always_comb begin
    prod_next  = {{W{1'b0}}, tw_data} * {{W{1'b0}}, rd_data_b};
    t_next     = W'(prod2 % Q_WIDE);
    sum        = {1'b0, u3} + {1'b0, t3};
    sum_red    = (sum >= Q_EXT) ? (sum - Q_EXT) : sum;
    u_out_next = W'(sum_red);
    v_out_next = (u3 < t3) ? (u3 - t3 + Q) : (u3 - t3);
  end

  // A new read that touches any address still in flight will see stale RAM contents
  always_comb begin
    hazard_hit = 1'b0;
    if (in_valid) begin
      hazard_hit = addr_hit(in_addr_u, v1, a1_u, a1_v)
                 | addr_hit(in_addr_v, v1, a1_u, a1_v)
                 | addr_hit(in_addr_u, v2, a2_u, a2_v)
                 | addr_hit(in_addr_v, v2, a2_u, a2_v)
                 | addr_hit(in_addr_u, v3, a3_u, a3_v)
                 | addr_hit(in_addr_v, v3, a3_u, a3_v)
                 | addr_hit(in_addr_u, wr_en, wr_addr_a, wr_addr_b)
                 | addr_hit(in_addr_v, wr_en, wr_addr_a, wr_addr_b);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      a1_u       <= '0;
      a1_v       <= '0;
      a2_u       <= '0;
      a2_v       <= '0;
      a3_u       <= '0;
      a3_v       <= '0;
      u2         <= '0;
      u3         <= '0;
      t3         <= '0;
      prod2      <= '0;
      wr_en      <= 1'b0;
      wr_addr_a  <= '0;
      wr_addr_b  <= '0;
      wr_data_a  <= '0;
      wr_data_b  <= '0;
      done_out   <= 1'b0;
      op_count   <= '0;
      hazard_err <= 1'b0;
    end else begin
      v1        <= in_valid;
      a1_u      <= in_addr_u & ADDR_MASK;
      a1_v      <= in_addr_v & ADDR_MASK;
      v2        <= v1;
      a2_u      <= a1_u;
      a2_v      <= a1_v;
      u2        <= rd_data_a;
      prod2     <= prod_next;
      v3        <= v2;
      a3_u      <= a2_u;
      a3_v      <= a2_v;
      u3        <= u2;
      t3        <= t_next;
      wr_en     <= v3;
      wr_addr_a <= a3_u;
      wr_addr_b <= a3_v;
      wr_data_a <= u_out_next;
      wr_data_b <= v_out_next;
      done_out  <= in_done & ~in_valid & ~v1 & ~v2 & ~v3;
      if (clr) begin
        op_count   <= '0;
        hazard_err <= 1'b0;
      end else begin
        if (wr_en)
          op_count <= op_count + (2*N_LOG)'(1);
        if (hazard_hit)
          hazard_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ntt_butterfly_exec.sv
// Scoreboard bench for ntt_butterfly_exec: directed butterflies against hand-computed
// results, hazard flag, clr, done timing and mid-flight reset.
module tb_ntt_butterfly_exec;

  localparam int N_LOG = 12;
  localparam int W = 32;
  localparam logic [W-1:0] Q = 32'd998244353;

  typedef struct {
    int unsigned      cyc;
    logic [N_LOG-1:0] au;
    logic [N_LOG-1:0] av;
    logic [W-1:0]     ea;
    logic [W-1:0]     eb;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clr;
  logic                 in_valid;
  logic [N_LOG-1:0]     in_addr_u, in_addr_v, in_addr_w;
  logic                 in_done;
  logic                 rd_en;
  logic [N_LOG-1:0]     rd_addr_a, rd_addr_b, tw_addr;
  logic [W-1:0]         rd_data_a, rd_data_b, tw_data;
  logic                 wr_en;
  logic [N_LOG-1:0]     wr_addr_a, wr_addr_b;
  logic [W-1:0]         wr_data_a, wr_data_b;
  logic                 busy;
  logic                 done_out;
  logic [2*N_LOG-1:0]   op_count;
  logic                 hazard_err;

  logic                 pre_en, pre_tw_en;
  logic [N_LOG-1:0]     pre_addr;
  logic [W-1:0]         pre_data;

  logic [W-1:0] coef_mem [0:4095];
  logic [W-1:0] tw_mem   [0:63];

  exp_t        sb[$];
  exp_t        mon_item;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          writes_seen = 0;

  ntt_butterfly_exec dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_addr_u(in_addr_u), .in_addr_v(in_addr_v), .in_addr_w(in_addr_w),
    .in_done(in_done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .tw_data(tw_data),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .busy(busy), .done_out(done_out), .op_count(op_count), .hazard_err(hazard_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAMs with read-old-data on read-during-write, plus a preload port
  always @(posedge clk) begin
    rd_data_a <= coef_mem[rd_addr_a];
    rd_data_b <= coef_mem[rd_addr_b];
    tw_data   <= tw_mem[tw_addr[5:0]];
    if (pre_en)    coef_mem[pre_addr] <= pre_data;
    if (pre_tw_en) tw_mem[pre_addr[5:0]] <= pre_data;
    if (wr_en) begin
      coef_mem[wr_addr_a] <= wr_data_a;
      coef_mem[wr_addr_b] <= wr_data_b;
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wr_en) begin
      writes_seen++;
      if (sb.size() == 0) begin
        check_output("unexpected_wr_en", 64'd1, 64'd0);
      end else begin
        mon_item = sb.pop_front();
        check_output("wr_latency", 64'(cyc), 64'(mon_item.cyc));
        check_output("wr_addr_a", 64'(wr_addr_a), 64'(mon_item.au));
        check_output("wr_addr_b", 64'(wr_addr_b), 64'(mon_item.av));
        check_output("wr_data_a", 64'(wr_data_a), 64'(mon_item.ea));
        check_output("wr_data_b", 64'(wr_data_b), 64'(mon_item.eb));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic is_tw, input int addr, input logic [W-1:0] val);
    pre_en    = !is_tw;
    pre_tw_en = is_tw;
    pre_addr  = N_LOG'(addr);
    pre_data  = val;
    step();
    pre_en    = 1'b0;
    pre_tw_en = 1'b0;
  endtask

  task automatic apply_stimulus(input int au, input int av, input int aw,
                                input logic [W-1:0] ea, input logic [W-1:0] eb, input bit expect_wr);
    in_valid  = 1'b1;
    in_addr_u = N_LOG'(au);
    in_addr_v = N_LOG'(av);
    in_addr_w = N_LOG'(aw);
    if (expect_wr)
      sb.push_back('{cyc + 4, N_LOG'(au), N_LOG'(av), ea, eb});
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_done = 1'b0;
    in_addr_u = '0; in_addr_v = '0; in_addr_w = '0;
    pre_en = 1'b0; pre_tw_en = 1'b0; pre_addr = '0; pre_data = '0;
    step();
    @(negedge clk);
    check_output("rst_wr_en", 64'(wr_en), 64'd0);
    check_output("rst_done_out", 64'(done_out), 64'd0);
    check_output("rst_op_count", 64'(op_count), 64'd0);
    check_output("rst_hazard_err", 64'(hazard_err), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    step();

    preload(1'b1, 0, 32'd3);
    preload(1'b1, 1, 32'd1);
    preload(1'b1, 2, Q - 1);
    preload(1'b1, 3, 32'd10);
    preload(1'b0, 0, 32'd5);   preload(1'b0, 1, 32'd7);
    preload(1'b0, 2, Q - 1);   preload(1'b0, 3, 32'd1);
    preload(1'b0, 4, 32'd0);   preload(1'b0, 5, 32'd0);
    preload(1'b0, 6, 32'd100); preload(1'b0, 7, 32'd2);
    preload(1'b0, 8, 32'd10);  preload(1'b0, 9, 32'd2);
    preload(1'b0, 10, Q - 1);  preload(1'b0, 11, Q - 1);
    preload(1'b0, 20, 32'd1);  preload(1'b0, 21, 32'd1);
    preload(1'b0, 30, 32'd3);
    preload(1'b0, 40, 32'd4);  preload(1'b0, 41, 32'd5);
    preload(1'b0, 42, 32'd6);
    rst = 1'b0;
    step();

    // Back-to-back directed butterflies, then the controller raises done
    apply_stimulus(0, 1, 0, 32'd26, 32'd998244337, 1'b1);
    apply_stimulus(2, 3, 1, 32'd0, 32'd998244351, 1'b1);
    apply_stimulus(4, 5, 2, 32'd0, 32'd0, 1'b1);
    apply_stimulus(6, 7, 3, 32'd120, 32'd80, 1'b1);
    apply_stimulus(8, 9, 2, 32'd8, 32'd12, 1'b1);
    apply_stimulus(10, 11, 2, 32'd0, 32'd998244351, 1'b1);
    in_done = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_output($sformatf("done_out_L+%0d", k), 64'(done_out), (k == 5) ? 64'd1 : 64'd0);
      if (k == 1) check_output("busy_draining", 64'(busy), 64'd1);
      if (k == 5) check_output("busy_idle", 64'(busy), 64'd0);
      step();
    end
    check_output("op_count_6", 64'(op_count), 64'd6);
    check_output("no_hazard", 64'(hazard_err), 64'd0);
    in_done = 1'b0;
    @(negedge clk);
    check_output("done_hold", 64'(done_out), 64'd1);
    step();
    @(negedge clk);
    check_output("done_fall", 64'(done_out), 64'd0);
    step();

    // Read of an address still in S1; stale value 1 is used for address 21
    apply_stimulus(20, 21, 1, 32'd2, 32'd0, 1'b1);
    apply_stimulus(21, 30, 1, 32'd4, 32'd998244351, 1'b1);
    repeat (8) step();
    @(negedge clk);
    check_output("hazard_sticky", 64'(hazard_err), 64'd1);
    check_output("op_count_8", 64'(op_count), 64'd8);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    @(negedge clk);
    check_output("clr_hazard", 64'(hazard_err), 64'd0);
    check_output("clr_op_count", 64'(op_count), 64'd0);
    step();

    // Read concurrent with the write stage; RAM returns old value 5 for address 41
    apply_stimulus(40, 41, 1, 32'd9, 32'd998244352, 1'b1);
    repeat (3) step();
    @(negedge clk);
    check_output("hazard_before_wr_stage", 64'(hazard_err), 64'd0);
    apply_stimulus(41, 42, 1, 32'd11, 32'd998244352, 1'b1);
    repeat (8) step();
    @(negedge clk);
    check_output("hazard_wr_stage", 64'(hazard_err), 64'd1);
    check_output("op_count_2", 64'(op_count), 64'd2);
    step();

    // Reset with three butterflies in flight: none may be written
    apply_stimulus(50, 51, 0, 32'd0, 32'd0, 1'b0);
    apply_stimulus(52, 53, 0, 32'd0, 32'd0, 1'b0);
    apply_stimulus(54, 55, 0, 32'd0, 32'd0, 1'b0);
    rst = 1'b1;
    step();
    @(negedge clk);
    check_output("midrst_busy", 64'(busy), 64'd0);
    check_output("midrst_wr_en", 64'(wr_en), 64'd0);
    check_output("midrst_op_count", 64'(op_count), 64'd0);
    check_output("midrst_hazard", 64'(hazard_err), 64'd0);
    check_output("midrst_wr_data_a", 64'(wr_data_a), 64'd0);
    check_output("midrst_wr_addr_b", 64'(wr_addr_b), 64'd0);
    step();
    rst = 1'b0;
    repeat (10) step();
    @(negedge clk);
    check_output("post_rst_busy", 64'(busy), 64'd0);
    step();

    // Post-reset operation on data written by the first batch
    apply_stimulus(6, 7, 3, 32'd920, 32'd998243673, 1'b1);
    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    step();
    @(negedge clk);
    check_output("final_op_count", 64'(op_count), 64'd1);
    check_output("scoreboard_empty", 64'(sb.size()), 64'd0);
    check_output("writes_seen", 64'(writes_seen), 64'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
